// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start bit, LSB-first data, stop bit, plus a one-entry holding register.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx #(
   parameter int CLOCK_FREQ = 50000000,
   parameter int BAUD_RATE  = 115200
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx
);

   localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic             tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
   logic             par_q, par_d;
`endif

   logic accept, bit_end;

   assign tx_ready = ~hold_full_q;
   assign tx_busy  = (state_q != IDLE);
   assign tx_done  = (state_q == STOP) && bit_end;
   assign tx       = tx_q;
   assign accept   = tx_start && tx_ready;
   assign bit_end  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

   always_comb begin
      state_d     = state_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
`ifdef UART_TX_PARITY_EN
      par_d       = par_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
               par_d   = ^tx_data;
`endif
               state_d = START;
            end
         end
         START: if (bit_end) state_d = DATA;
         DATA: begin
            if (bit_end) begin
               if (bit_q == 3'd7) begin
                  bit_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = shift_q >> 1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (bit_end) state_d = STOP;
`endif
         STOP: begin
            if (bit_end) begin
               if (hold_full_q) begin
                  shift_d     = hold_q;
`ifdef UART_TX_PARITY_EN
                  par_d       = ^hold_q;
`endif
                  hold_full_d = 1'b0;
                  state_d     = START;
               end else if (accept) begin
                  shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
                  par_d   = ^tx_data;
`endif
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Mid-frame accepts park in the holding register, except the stop-end cycle which loads directly.
      if (accept && (state_q != IDLE) && !((state_q == STOP) && bit_end)) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end

      if ((state_q == IDLE) || bit_end || (state_d != state_q))
         cnt_d = '0;
      else
         cnt_d = cnt_q + CNT_W'(1);

      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_d = par_d;
`endif
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_q       <= 3'd0;
         shift_q     <= 8'd0;
         hold_q      <= 8'd0;
         hold_full_q <= 1'b0;
         tx_q        <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         tx_q        <= tx_d;
`ifdef UART_TX_PARITY_EN
         par_q       <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4; expected frames are built from the byte values.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   localparam int FC = 4 * FB;

   logic       clock = 1'b0;
   logic       reset;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_ready, tx_busy, tx_done, tx;

   uart_tx #(.CLOCK_FREQ(400), .BAUD_RATE(100)) dut (
      .clock(clock), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
      .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .tx(tx)
   );

   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_pass = 0;

   bit tx_log [0:255];
   bit dn_log [0:255];
   bit rd_log [0:255];
   bit bz_log [0:255];

   int         ev_cyc [0:3];
   logic [7:0] ev_dat [0:3];
   int         ev_n;
   int         rst_cyc;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic rec(input int c);
      tx_log[c] = tx; dn_log[c] = tx_done; rd_log[c] = tx_ready; bz_log[c] = tx_busy;
   endtask

   task automatic do_reset();
      reset = 1'b1; tx_start = 1'b0; tx_data = 8'h00;
      tick(); tick();
      reset = 1'b0;
   endtask

   // Cycle c's inputs are applied, then the edge, then outputs of cycle c+1 are logged.
   task automatic run(input int ncyc);
      rec(0);
      for (int c = 0; c < ncyc; c++) begin
         tx_start = 1'b0;
         reset    = (c == rst_cyc);
         for (int e = 0; e < ev_n; e++)
            if (ev_cyc[e] == c) begin tx_start = 1'b1; tx_data = ev_dat[e]; end
         tick();
         rec(c + 1);
      end
      tx_start = 1'b0; reset = 1'b0; rst_cyc = -1; ev_n = 0;
   endtask

   function automatic bit fbit(input logic [7:0] d, input int b);
      if (b == 0) return 1'b0;
      if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
      if (b == 9) return ^d;
`endif
      return 1'b1;
   endfunction

   task automatic chk_frame(input string tag, input logic [7:0] d, input int s);
      logic [3:0] got;
      for (int b = 0; b < FB; b++) begin
         for (int k = 0; k < 4; k++) got[k] = tx_log[s + 4*b + k];
         chk($sformatf("%s_bit%0d", tag, b), {28'd0, got}, {28'd0, {4{fbit(d, b)}}});
      end
   endtask

   function automatic int ndone(input int lo, input int hi);
      int n = 0;
      for (int i = lo; i <= hi; i++) n += dn_log[i];
      return n;
   endfunction

   initial begin
      rst_cyc = -1; ev_n = 0;
      do_reset();
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", tx_busy, 1'b0);
      chk("rst_ready", tx_ready, 1'b1);
      chk("rst_done", tx_done, 1'b0);

      // Single frame 0x55
      ev_cyc[0] = 0; ev_dat[0] = 8'h55; ev_n = 1;
      run(FC + 4);
      chk("f55_idle0", tx_log[0], 1'b1);
      chk_frame("f55", 8'h55, 1);
      chk("f55_done_at_end", dn_log[FC], 1'b1);
      chk("f55_done_count", ndone(0, FC + 4), 1);
      chk("f55_busy_mid", bz_log[1], 1'b1);
      chk("f55_busy_after", bz_log[FC + 1], 1'b0);
      chk("f55_idle_after", tx_log[FC + 2], 1'b1);

      // Holding register: 0xA3 then 0x0F queued at cycle 10
      do_reset();
      ev_cyc[0] = 0; ev_dat[0] = 8'hA3; ev_cyc[1] = 10; ev_dat[1] = 8'h0F; ev_n = 2;
      run(2*FC + 4);
      begin
         int z = 0;
         for (int i = 11; i <= FC; i++) z += (rd_log[i] == 1'b0);
         chk("hold_ready_low", z, FC - 10);
      end
      chk("hold_ready_c10", rd_log[10], 1'b1);
      chk("hold_ready_rise", rd_log[FC + 1], 1'b1);
      chk_frame("hA3", 8'hA3, 1);
      chk_frame("h0F", 8'h0F, FC + 1);
      chk("hold_done1", dn_log[FC], 1'b1);
      chk("hold_done2", dn_log[2*FC], 1'b1);
      chk("hold_done_count", ndone(0, 2*FC + 4), 2);

      // Third request while holding register full is dropped
      do_reset();
      ev_cyc[0] = 0; ev_dat[0] = 8'h11; ev_cyc[1] = 5; ev_dat[1] = 8'h22;
      ev_cyc[2] = 6; ev_dat[2] = 8'h33; ev_n = 3;
      run(3*FC + 4);
      chk_frame("d11", 8'h11, 1);
      chk_frame("d22", 8'h22, FC + 1);
      chk("drop_done_count", ndone(0, 3*FC + 4), 2);
      begin
         int ones = 0;
         for (int i = 2*FC + 1; i <= 3*FC + 4; i++) ones += tx_log[i];
         chk("drop_line_idle", ones, FC + 4);
         chk("drop_busy_after", bz_log[2*FC + 1], 1'b0);
      end

      // Reset during data bit 3 of 0xF0 (frame cycles 17-20), with a start request ignored
      do_reset();
      ev_cyc[0] = 0; ev_dat[0] = 8'hF0; ev_cyc[1] = 18; ev_dat[1] = 8'hFF; ev_n = 2;
      rst_cyc = 18;
      run(FC + 8);
      chk("abort_in_bit3", tx_log[18], 1'b0);
      chk("abort_tx", tx_log[19], 1'b1);
      chk("abort_busy", bz_log[19], 1'b0);
      chk("abort_ready", rd_log[19], 1'b1);
      chk("abort_no_done", ndone(0, FC + 8), 0);
      chk("abort_stays_idle", bz_log[FC + 8], 1'b0);

      // Start exactly in the tx_done cycle, holding register empty
      do_reset();
      ev_cyc[0] = 0; ev_dat[0] = 8'h3C; ev_cyc[1] = FC; ev_dat[1] = 8'h5A; ev_n = 2;
      run(2*FC + 4);
      chk("b2b_done1", dn_log[FC], 1'b1);
      chk_frame("b3C", 8'h3C, 1);
      chk_frame("b5A", 8'h5A, FC + 1);
      chk("b2b_done2", dn_log[2*FC], 1'b1);
      chk("b2b_done_count", ndone(0, 2*FC + 4), 2);

`ifdef UART_TX_PARITY_EN
      do_reset();
      ev_cyc[0] = 0; ev_dat[0] = 8'h07; ev_n = 1;
      run(50);
      chk("par_bit", {tx_log[37], tx_log[38], tx_log[39], tx_log[40]}, 4'b1111);
      chk("par_stop", {tx_log[41], tx_log[42], tx_log[43], tx_log[44]}, 4'b1111);
      chk("par_data7", tx_log[36], 1'b0);
      chk("par_done44", dn_log[44], 1'b1);
      chk("par_done_count", ndone(0, 50), 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50000000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning serial bit rate in bits/s.
REQ-003 SHALL have port clock  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port tx_start  input  1  request to send tx_data; accepted only when tx_ready=1.
REQ-006 SHALL have port tx_data  input  8  byte to send, sampled in the accept cycle.
REQ-007 SHALL have port tx_ready  output  1  holding register empty, so a new byte can be accepted.
REQ-008 SHALL have port tx_busy  output  1  a frame is on the line (state != IDLE).
REQ-009 SHALL have port tx_done  output  1  one-cycle pulse in the last cycle of each stop bit.
REQ-010 SHALL have port tx  output  1  serial line; idle high; registered output.

Function
REQ-011 SHALL compute CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE (integer division); every bit lasts exactly CLKS_PER_BIT cycles.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP; tx = 1, 0, shift[0], parity, 1 respectively.
REQ-013 SHALL send data bits LSB first, using a 3-bit bit index that advances at each bit-period end.
REQ-014 SHALL clear the baud counter on every state entry; a bit-period end is counter == CLKS_PER_BIT-1.
REQ-015 SHALL, in IDLE, load an accepted byte directly into the shift register, enter START, and drive tx low from the next cycle (latency 1).
REQ-016 SHALL, when not in IDLE, store an accepted byte in a one-entry holding register, deasserting tx_ready the next cycle.
REQ-017 SHALL ignore tx_start when tx_ready=0 (byte dropped, no state change).
REQ-018 SHALL, at the end of STOP with the holding register full, move the holding register into the shift register and enter START with no idle cycle; tx_ready rises the next cycle.
REQ-019 SHALL, at the end of STOP with the holding register empty and tx_start=1 in the same cycle, load tx_data directly and enter START (back-to-back).
REQ-020 SHALL otherwise return to IDLE at the end of STOP.
REQ-021 SHALL pulse tx_done for every frame, including back-to-back frames.
REQ-022 SHALL assert tx_busy in START, DATA, PARITY and STOP.

Reset
REQ-023 SHALL, on reset=1 at a clock edge, set state=IDLE, tx=1, tx_busy=0, tx_done=0, tx_ready=1, counter=0, bit index=0, and mark the holding register empty.
REQ-024 SHALL abort any frame in progress on reset; tx returns high the cycle after reset, and tx_start is ignored while reset=1.

Configuration
REQ-025 SHALL, with macro UART_TX_PARITY_EN defined, insert after data bit 7 one PARITY bit equal to the XOR of the 8 data bits (even parity), giving an 11-bit frame.
REQ-026 SHALL, without UART_TX_PARITY_EN, omit the PARITY state and go from DATA directly to STOP, giving a 10-bit frame.

Verification (CLOCK_FREQ=400, BAUD_RATE=100, so CLKS_PER_BIT=4)
REQ-027 SHALL cover: idle, tx_start with 0x55 at cycle 0 -> tx over cycles 1-40 is 0,1,0,1,0,1,0,1,0,1, each 4 cycles; tx_done=1 at cycle 40; tx_busy=0 at cycle 41.
REQ-028 SHALL cover: 0xA3 accepted at cycle 0, 0x0F accepted at cycle 10 -> tx_ready=0 in cycles 11-40; second start bit begins at cycle 41 with no gap; two tx_done pulses, 40 cycles apart.
REQ-029 SHALL cover: 0x11 at cycle 0, 0x22 at cycle 5, 0x33 at cycle 6 -> 0x33 dropped; exactly two frames (0x11, 0x22) are seen on tx.
REQ-030 SHALL cover: reset=1 for one cycle during data bit 3 of 0xF0 -> next cycle tx=1, tx_busy=0, tx_ready=1, and no tx_done pulse.
REQ-031 SHALL cover (UART_TX_PARITY_EN defined): 0x07 -> parity bit 1 over cycles 37-40, stop bit over cycles 41-44, tx_done=1 at cycle 44.
REQ-032 SHALL cover: tx_start with 0x5A exactly in the tx_done cycle of a frame, holding register empty -> start bit begins the next cycle and 0x5A is sent correctly.
